// File: rtl/votos_pkg.sv
// votos_pkg: shared session state encoding and default sizing for the vote-capture stage.
`default_nettype none

package votos_pkg;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      VOTACAO = 2'd1,
      FECHADO = 2'd2
   } estado_t;

   localparam int N_ELEITORES_PADRAO = 3;
   localparam int TIMEOUT_PADRAO     = 1000;

endpackage

`default_nettype wire

// File: rtl/temporizador_sessao.sv
// temporizador_sessao: session timeout counter.
// expirou_o flags the last allowed cycle, so the close lands TIMEOUT_CICLOS cycles after opening.
`default_nettype none

module temporizador_sessao #(
   parameter int TIMEOUT_CICLOS = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic limpar_i,
   input  logic conta_i,
   output logic expirou_o
);

   localparam int LARGURA = (TIMEOUT_CICLOS < 1) ? 1 : $clog2(TIMEOUT_CICLOS + 1);

   generate
      if (TIMEOUT_CICLOS == 0) begin : g_sem_timeout
         assign expirou_o = 1'b0;
      end else begin : g_com_timeout
         logic [LARGURA-1:0] timer_q;
         logic [LARGURA-1:0] timer_d;

         always_comb begin
            timer_d = timer_q;
            if (limpar_i) begin
               timer_d = '0;
            end else if (conta_i) begin
               timer_d = timer_q + LARGURA'(1);
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               timer_q <= '0;
            end else begin
               timer_q <= timer_d;
            end
         end

         assign expirou_o = (timer_q == LARGURA'(TIMEOUT_CICLOS - 1));
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/coleta_votos.sv
// coleta_votos: vote-capture FSM; one vote per voter per session, registered result V with valido/fim.
`default_nettype none

module coleta_votos
   import votos_pkg::*;
#(
   parameter int N_ELEITORES    = N_ELEITORES_PADRAO,
   parameter int TIMEOUT_CICLOS = TIMEOUT_PADRAO
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   abrir,
   input  logic                   encerrar,
   input  logic [N_ELEITORES-1:0] voto_en,
   input  logic [N_ELEITORES-1:0] escolha,
   output logic [N_ELEITORES-1:0] V,
   output logic [N_ELEITORES-1:0] votou,
   output logic                   aberta,
   output logic                   valido,
   output logic                   fim
);

   estado_t                estado_q, estado_d;
   logic [N_ELEITORES-1:0] votou_q, votou_d;
   logic [N_ELEITORES-1:0] voto_reg_q, voto_reg_d;
   logic [N_ELEITORES-1:0] v_q, v_d;
   logic                   fim_q, fim_d;

   logic [N_ELEITORES-1:0] aceitos;
   logic [N_ELEITORES-1:0] votou_mais;
   logic [N_ELEITORES-1:0] voto_mais;
   logic                   expirou;
   logic                   fechar;

   temporizador_sessao #(
      .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
   ) u_temporizador (
      .clk       (clk),
      .rst       (rst),
      .limpar_i  (estado_q != VOTACAO),
      .conta_i   (estado_q == VOTACAO),
      .expirou_o (expirou)
   );

   // Votes landing in the closing cycle must reach V, so merge them before deciding.
   assign aceitos    = voto_en & ~votou_q;
   assign votou_mais = votou_q | aceitos;
   assign voto_mais  = (voto_reg_q & ~aceitos) | (escolha & aceitos);
   assign fechar     = (&votou_mais) | encerrar | expirou;

   always_comb begin
      estado_d   = estado_q;
      votou_d    = votou_q;
      voto_reg_d = voto_reg_q;
      v_d        = v_q;
      fim_d      = 1'b0;
      unique case (estado_q)
         OCIOSO: begin
            if (abrir) begin
               estado_d   = VOTACAO;
               votou_d    = '0;
               voto_reg_d = '0;
            end
         end
         VOTACAO: begin
            votou_d    = votou_mais;
            voto_reg_d = voto_mais;
            if (fechar) begin
               estado_d = FECHADO;
               v_d      = voto_mais;
               fim_d    = 1'b1;
            end
         end
         FECHADO: begin
            if (abrir) begin
               estado_d   = VOTACAO;
               v_d        = '0;
               votou_d    = '0;
               voto_reg_d = '0;
            end
         end
         default: estado_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q   <= OCIOSO;
         votou_q    <= '0;
         voto_reg_q <= '0;
         v_q        <= '0;
         fim_q      <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         votou_q    <= votou_d;
         voto_reg_q <= voto_reg_d;
         v_q        <= v_d;
         fim_q      <= fim_d;
      end
   end

   assign V      = v_q;
   assign votou  = votou_q;
   assign aberta = (estado_q == VOTACAO);
   assign valido = (estado_q == FECHADO);
   assign fim    = fim_q;

endmodule

`default_nettype wire

// File: tb/tb_coleta_votos.sv
// tb_coleta_votos: table-driven scoreboard bench for coleta_votos (timeout 8) plus a timeout-disabled instance.
`default_nettype none

module tb_coleta_votos;

   typedef struct {
      string      nome;
      logic       abrir;
      logic       encerrar;
      logic [2:0] voto_en;
      logic [2:0] escolha;
      logic [2:0] v;
      logic [2:0] vt;
      logic       a;
      logic       va;
      logic       f;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       abrir = 1'b0;
   logic       encerrar = 1'b0;
   logic [2:0] voto_en = '0;
   logic [2:0] escolha = '0;
   logic [2:0] V, votou, V0, votou0;
   logic       aberta, valido, fim, aberta0, valido0, fim0;

   int   n_checks = 0;
   int   n_fail = 0;
   vec_t tbl[$];
   vec_t sb[$];

   coleta_votos #(.N_ELEITORES(3), .TIMEOUT_CICLOS(8)) dut (
      .clk(clk), .rst(rst), .abrir(abrir), .encerrar(encerrar),
      .voto_en(voto_en), .escolha(escolha),
      .V(V), .votou(votou), .aberta(aberta), .valido(valido), .fim(fim)
   );

   coleta_votos #(.N_ELEITORES(3), .TIMEOUT_CICLOS(0)) dut0 (
      .clk(clk), .rst(rst), .abrir(abrir), .encerrar(encerrar),
      .voto_en(voto_en), .escolha(escolha),
      .V(V0), .votou(votou0), .aberta(aberta0), .valido(valido0), .fim(fim0)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(string nm, logic ab, logic enc, logic [2:0] en, logic [2:0] esc,
                               logic [2:0] v, logic [2:0] vt, logic a, logic va, logic f);
      vec_t r;
      r.nome = nm; r.abrir = ab; r.encerrar = enc; r.voto_en = en; r.escolha = esc;
      r.v = v; r.vt = vt; r.a = a; r.va = va; r.f = f;
      return r;
   endfunction

   task automatic chk(string nm, logic [8:0] got, logic [8:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got V=%b votou=%b aberta=%b valido=%b fim=%b, expected V=%b votou=%b aberta=%b valido=%b fim=%b",
                  nm, got[8:6], got[5:3], got[2], got[1], got[0], exp[8:6], exp[5:3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic step(input vec_t v);
      vec_t e;
      @(negedge clk);
      abrir = v.abrir; encerrar = v.encerrar; voto_en = v.voto_en; escolha = v.escolha;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk(e.nome, {V, votou, aberta, valido, fim}, {e.v, e.vt, e.a, e.va, e.f});
   endtask

   task automatic pulso_reset(string nm);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk(nm, {V, votou, aberta, valido, fim}, 9'b0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int ruins;

      // Full vote, double vote, simultaneous close, re-open.
      tbl.push_back(mk("abre_ignora_voto", 1, 0, 3'b111, 3'b111, 3'b000, 3'b000, 1, 0, 0));
      tbl.push_back(mk("cheio_v0",         0, 0, 3'b001, 3'b001, 3'b000, 3'b001, 1, 0, 0));
      tbl.push_back(mk("cheio_ocioso1",    0, 0, 3'b000, 3'b000, 3'b000, 3'b001, 1, 0, 0));
      tbl.push_back(mk("cheio_v1",         0, 0, 3'b010, 3'b000, 3'b000, 3'b011, 1, 0, 0));
      tbl.push_back(mk("cheio_ocioso2",    0, 0, 3'b000, 3'b000, 3'b000, 3'b011, 1, 0, 0));
      tbl.push_back(mk("cheio_fecha",      0, 0, 3'b100, 3'b100, 3'b101, 3'b111, 0, 1, 1));
      tbl.push_back(mk("cheio_mantem",     0, 0, 3'b000, 3'b000, 3'b101, 3'b111, 0, 1, 0));
      tbl.push_back(mk("duplo_reabre",     1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0));
      tbl.push_back(mk("duplo_1o",         0, 0, 3'b010, 3'b010, 3'b000, 3'b010, 1, 0, 0));
      tbl.push_back(mk("duplo_2o",         0, 0, 3'b010, 3'b000, 3'b000, 3'b010, 1, 0, 0));
      tbl.push_back(mk("duplo_fecha",      0, 1, 3'b000, 3'b000, 3'b010, 3'b010, 0, 1, 1));
      tbl.push_back(mk("simult_reabre",    1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0));
      tbl.push_back(mk("simult_fecha",     0, 1, 3'b111, 3'b011, 3'b011, 3'b111, 0, 1, 1));
      tbl.push_back(mk("simult_fim_unico", 0, 1, 3'b111, 3'b100, 3'b011, 3'b111, 0, 1, 0));
      tbl.push_back(mk("r_abre",           1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0));
      tbl.push_back(mk("r_todos_sim",      0, 0, 3'b111, 3'b111, 3'b111, 3'b111, 0, 1, 1));
      tbl.push_back(mk("r_reabre_limpa",   1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0));
      tbl.push_back(mk("r_abrir_em_vot",   1, 0, 3'b001, 3'b001, 3'b000, 3'b001, 1, 0, 0));
      tbl.push_back(mk("r_encerra",        0, 1, 3'b000, 3'b000, 3'b001, 3'b001, 0, 1, 1));
      tbl.push_back(mk("r_encerra_fech",   0, 1, 3'b010, 3'b010, 3'b001, 3'b001, 0, 1, 0));

      // Reset state, then reset in the middle of a session.
      #12;
      chk("reset_inicial", {V, votou, aberta, valido, fim}, 9'b0);
      @(negedge clk);
      rst = 1'b0;
      step(mk("rm_abre", 1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0));
      step(mk("rm_voto", 0, 0, 3'b001, 3'b001, 3'b000, 3'b001, 1, 0, 0));
      pulso_reset("rm_reset_async");
      step(mk("rm_ocioso_ignora", 0, 0, 3'b111, 3'b111, 3'b000, 3'b000, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i]);
      end

      // Timeout of 8: the close lands on the 8th cycle spent in VOTACAO.
      step(mk("to_abre", 1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0));
      step(mk("to_voto2", 0, 0, 3'b100, 3'b100, 3'b000, 3'b100, 1, 0, 0));
      for (int i = 0; i < 6; i++) begin
         step(mk("to_espera", 0, 0, 3'b000, 3'b000, 3'b000, 3'b100, 1, 0, 0));
      end
      step(mk("to_fecha", 0, 0, 3'b000, 3'b000, 3'b100, 3'b100, 0, 1, 1));
      step(mk("to_mantem", 0, 0, 3'b001, 3'b001, 3'b100, 3'b100, 0, 1, 0));

      // encerrar is not honoured in OCIOSO, even alongside abrir.
      pulso_reset("oc_reset");
      step(mk("oc_encerra", 0, 1, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0));
      step(mk("oc_abre_encerra", 1, 1, 3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0));
      step(mk("oc_fecha_vazio", 0, 1, 3'b000, 3'b000, 3'b000, 3'b000, 0, 1, 1));

      // Timeout disabled: the session must stay open indefinitely.
      pulso_reset("sem_to_reset");
      step(mk("sem_to_abre", 1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0));
      @(negedge clk);
      abrir = 1'b0; encerrar = 1'b0; voto_en = '0; escolha = '0;
      ruins = 0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #1;
         if (!aberta0 || fim0 || valido0) ruins++;
      end
      n_checks++;
      if (ruins != 0) begin
         n_fail++;
         $display("FAIL sem_timeout: %0d cycles out of VOTACAO, required 0", ruins);
      end
      @(negedge clk);
      encerrar = 1'b1;
      @(posedge clk);
      #1;
      chk("sem_to_encerra", {V0, votou0, aberta0, valido0, fim0}, {3'b000, 3'b000, 1'b0, 1'b1, 1'b1});
      @(negedge clk);
      encerrar = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/coleta_votos.md
Name: coleta_votos

Overview:
Sequential vote-capture stage that sits directly upstream of the combinational vote counter. It opens a voting session, accepts at most one vote per voter, and closes the session when all voters have voted, when an operator ends it, or on timeout. It then presents the registered vote vector V[2:0] with a valid flag for the counter to tally into R[3:0].

Parameters:
N_ELEITORES, 3, number of voters; the width of V, voto_en, escolha and votou.
TIMEOUT_CICLOS, 1000, clock cycles in VOTACAO before forced close; 0 disables the timeout.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
abrir  input  1  start a new session; sampled in OCIOSO and FECHADO.
encerrar  input  1  operator close request; honoured only in VOTACAO.
voto_en  input  N_ELEITORES  per-voter single-cycle confirm strobe.
escolha  input  N_ELEITORES  per-voter choice (1 = sim, 0 = nao), sampled with voto_en[i].
V  output  N_ELEITORES  registered session result for the downstream counter.
votou  output  N_ELEITORES  registered flags: voter i has voted this session.
aberta  output  1  high while in VOTACAO.
valido  output  1  high while in FECHADO; V is stable and final.
fim  output  1  one-cycle pulse on the cycle the FSM enters FECHADO.

Behaviour:
- Reset (async, any time, including mid-session):
  - Outputs: V=0, votou=0, aberta=0, valido=0, fim=0.
  - Internals: voto_reg=0, timer=0, estado=OCIOSO.
- FSM states are OCIOSO, VOTACAO and FECHADO. All outputs are registered.
- OCIOSO:
  - abrir=1 -> VOTACAO next cycle.
  - On that edge, clear votou, voto_reg and timer. V stays 0.
  - voto_en is ignored in OCIOSO, including in the same cycle as abrir.
- VOTACAO (aberta=1):
  - For each i with voto_en[i]=1 and votou[i]=0: votou[i]<=1 and voto_reg[i]<=escolha[i].
  - A strobe from a voter with votou[i]=1 is ignored; the first vote is final.
  - Several voters may vote in the same cycle; all are accepted.
  - abrir is ignored in VOTACAO.
  - timer increments each cycle in VOTACAO. Its width is $clog2(TIMEOUT_CICLOS+1), minimum 1.
  - Close condition, evaluated every cycle:
    - (votou | accepted_this_cycle) is all ones, OR
    - encerrar=1, OR
    - TIMEOUT_CICLOS!=0 and timer==TIMEOUT_CICLOS-1.
  - On close, go to FECHADO next cycle.
  - Votes accepted in the closing cycle count, including simultaneous encerrar/timeout.
  - Voters who never voted contribute 0 to V.
- Closing edge:
  - V <= voto_reg merged with the votes accepted that cycle.
  - valido <= 1, aberta <= 0, fim <= 1 for exactly one cycle.
- FECHADO:
  - V and valido hold. voto_en and encerrar are ignored.
  - abrir=1 -> VOTACAO next cycle. On that edge: V=0, valido=0, votou=0, voto_reg=0, timer=0.
- Latency:
  - From the last required voto_en (or encerrar) cycle to valido=1 and fim=1: one clock.
  - From abrir to aberta=1: one clock.
- With the default N_ELEITORES=3, V feeds the counter's V[2:0] directly.

Decomposition:
- Shared package votos_pkg holds:
  - estado_t enum {OCIOSO, VOTACAO, FECHADO}
  - localparam N_ELEITORES_PADRAO=3
  - localparam TIMEOUT_PADRAO=1000
- One natural sub-module, temporizador_sessao:
  - Parameterised timeout counter with clear/enable inputs and an expirou output.
  - Expiry is combinational on timer==TIMEOUT_CICLOS-1 and is tied to 0 when TIMEOUT_CICLOS=0.
- The FSM and vote registers remain in coleta_votos.

Test Plan:
1. Reset mid-session:
   - Stimulus: abrir, vote voter0=1, then assert rst asynchronously between clock edges.
   - Response: all outputs 0 immediately, estado OCIOSO.
   - After release: voto_en has no effect until abrir.
2. Full vote:
   - Stimulus: abrir; votes 1,0,1 on cycles 2,4,6.
   - Response: V=3'b101, valido=1 and fim pulse one cycle after the cycle-6 strobe; downstream R matches the counter for 101.
3. Double vote:
   - Stimulus: voter1 votes 1, later voter1 votes 0.
   - Response: votou=3'b010 unchanged; final V[1]=1.
4. Simultaneous:
   - Stimulus: all three voto_en in one cycle with escolha=3'b011, plus encerrar in the same cycle.
   - Response: single close; V=3'b011; fim high exactly one cycle.
5. Timeout:
   - Stimulus: TIMEOUT_CICLOS=8, only voter2 votes 1.
   - Response: close after 8 cycles in VOTACAO; V=3'b100, votou=3'b100.
   - With TIMEOUT_CICLOS=0: no close after 2000 cycles.
6. Re-open:
   - Stimulus: in FECHADO with V=3'b111, assert abrir.
   - Response: next cycle V=0, valido=0, aberta=1, votou=0; encerrar and abrir asserted in OCIOSO/FECHADO produce no fim.
